mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Shares one 4-bit output channel between four requesters using a valid/ready handshake and round-robin priority.
- The grant index selects the winning requester's data through a 4:1 mux path. Data is captured in a single registered output stage.
- Sits in front of any single-consumer sink that takes data from four sources. Sustains one transfer per cycle.

Parameters:
- DATA_W, 4, width of each requester's data and of out_data.
- N_REQ, 4, number of requesters. Fixed at 4; elaboration fails on any other value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data  input  4*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  4  one-hot (or zero) accept; bit i high means requester i transfers this cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_W  registered winning data.
- out_sel  output  2  index of the requester that produced out_data.
- out_ready  input  1  sink accepts out_data this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while rst_n=0.
- Reset asserted mid-transfer discards the held word immediately (out_valid drops asynchronously). No requester is credited with a transfer in that cycle.
- States, encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: load = !out_valid || out_ready. The register is free, or it drains this cycle.
- Pick, combinational: when load=1, the winner is the first requester with in_valid set, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
- in_ready: in_ready[winner]=1 only when load=1 and some in_valid is set; all other bits are 0.
- A requester's transfer is the cycle in which in_valid[i] and in_ready[i] are both high.
- On a transfer, at the next edge:
  - out_data <= in_data slice of the winner.
  - out_sel <= winner.
  - out_valid <= 1.
  - ptr <= winner+1 mod 4 (3 wraps to 0).
- Load with no in_valid set: out_valid <= 0. ptr, out_data and out_sel hold.
- No load (FULL and !out_ready): all registers hold and in_ready=0.
- Transitions:
  - EMPTY -> FULL on any transfer.
  - FULL -> FULL on out_ready together with a transfer (back-to-back, full throughput).
  - FULL -> EMPTY on out_ready with no in_valid set.
  - FULL -> FULL with hold when out_ready=0.
- Latency: one cycle from the input transfer edge to out_valid/out_data.
- Ordering: words from any one requester leave in the order they were accepted.
- Fairness: a requester holding in_valid high is granted within 4 load cycles.
- Pointer behaviour:
  - ptr advances only on a grant, never on idle cycles.
  - A lone requester wins every load cycle, regardless of ptr.
- Requester rules, checked by bench assertions:
  - in_data must stay stable while in_valid=1 and in_ready=0.
  - in_valid must not drop before its transfer.
- X-handling: in_data of non-winning requesters may be X; out_data must not become X because of them.
- Output stability: out_data and out_sel are stable while out_valid=1 and out_ready=0.

Decomposition:
- Package mux4_arb_pkg:
  - localparam N_REQ=4.
  - typedef logic [1:0] req_idx_t.
  - function next_idx(req_idx_t) (mod-4 increment).
- Sub-module rr_pick4, purely combinational.
  - Inputs: 4-bit valid and a req_idx_t pointer.
  - Outputs: req_idx_t winner and a found flag.
  - Implemented as rotate, priority-encode, rotate back.
- The top level holds the output register, ptr, load logic and the 4:1 data select.

Test Plan:
- Reset: drive rst_n=0 with in_valid=4'b1111 -> out_valid=0, in_ready=0, out_data=0. Release reset, out_ready=1 -> the first grant is requester 0 (ptr=0), and out_sel=0 appears one cycle later.
- Full round-robin: in_valid=4'b1111, data {a,b,c,d} on requesters 0..3, out_ready=1 held -> one word per cycle with out_sel sequence 0,1,2,3,0 and out_data a,b,c,d,a.
- Backpressure: FULL with out_data=c, out_sel=2, out_ready=0 for 3 cycles -> out_data and out_sel stay c/2, in_ready=0. Raising out_ready -> next winner is 3.
- Sparse and wrap: ptr=3, in_valid=4'b0101 -> requester 0 wins (wraps past 3), then requester 2, then requester 0 again.
- X tolerance: in_data of requester 3 = 'x, in_valid=4'b0011 -> outputs 7 then 10, never X. After raising in_valid[3], requester 3's word 'x passes through with out_sel=3.
- Mid-operation reset: FULL with out_ready=0, pulse rst_n low for half a cycle -> out_valid drops asynchronously and ptr=0. After release, the next grant follows ptr=0.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the four-way round-robin output arbiter.
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] req_idx_t;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set valid bit at or after ptr, wrapping mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [3:0] valid,
    input  req_idx_t   ptr,
    output req_idx_t   winner,
    output logic       found
);

    logic [3:0] rot_s;
    req_idx_t   off_s;

    // Rotate the request vector so the requester at ptr sits in bit 0.
    always_comb begin
        rot_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rot_s[k] = valid[ptr + 2'(k)];
        end
    end

    // Priority-encode the rotated vector; offset 0 is the highest priority.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    assign winner = ptr + off_s;
    assign found  = |valid;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters share one registered output word; round-robin grant, full throughput.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N_REQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          in_valid,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    output logic [N_REQ-1:0]          in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [1:0]                out_sel,
    input  logic                      out_ready
);

    if (N_REQ != 4) begin : g_bad_n_req
        $error("mux4_rr_arbiter supports only N_REQ = 4");
    end

    req_idx_t            ptr_r;
    req_idx_t            winner_s;
    logic                found_s;
    logic                load_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   win_data_s;

    rr_pick4 u_pick (
        .valid  (in_valid[3:0]),
        .ptr    (ptr_r),
        .winner (winner_s),
        .found  (found_s)
    );

    // The register can take a new word when it is empty or being drained.
    assign load_s = !out_valid || out_ready;
    assign xfer_s = load_s && found_s && rst_n;

    // One-hot accept for the winner; nobody is accepted while reset is held.
    always_comb begin
        in_ready = {N_REQ{1'b0}};
        if (xfer_s) begin
            in_ready[winner_s] = 1'b1;
        end else begin
            in_ready = {N_REQ{1'b0}};
        end
    end

    // Select only the winner's slice so unknown data on losers cannot leak through.
    always_comb begin
        win_data_s = {DATA_W{1'b0}};
        case (winner_s)
            2'd0:    win_data_s = in_data[0*DATA_W +: DATA_W];
            2'd1:    win_data_s = in_data[1*DATA_W +: DATA_W];
            2'd2:    win_data_s = in_data[2*DATA_W +: DATA_W];
            2'd3:    win_data_s = in_data[3*DATA_W +: DATA_W];
            default: win_data_s = in_data[0*DATA_W +: DATA_W];
        endcase
    end

    // Output register and round-robin pointer; ptr moves only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_sel   <= 2'd0;
            ptr_r     <= 2'd0;
        end else if (load_s) begin
            if (found_s) begin
                out_valid <= 1'b1;
                out_data  <= win_data_s;
                out_sel   <= winner_s;
                ptr_r     <= next_idx(winner_s);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
